// File: rtl/snake_grid_renderer.sv
// -----------------------------------------------------------------------------
// snake_grid_renderer
//
// Pixel renderer for the Snake VGA path. The scan position (X, Y) is mapped
// onto a grid of square blocks. Each block is classified as head, body, fruit
// or empty, and the per-pixel colour index is produced for the VGA stage. The
// snake is held as a head register plus a shift buffer of body segments. New
// heads arrive through a valid/ready handshake. They are committed only on
// the commit line (X==0, Y==COMMIT_LINE), so a visible frame never shows a
// half-updated snake.
//
// Ports
//   clock_25, reset          pixel clock, synchronous active-high reset
//   X, Y                     current scan position
//   fruit_x, fruit_y         fruit block, sampled every pixel
//   move_valid / move_ready  move handshake; move_ready=1 when no move is pending
//   new_head_x/y, grow       offered head block; grow keeps the tail
//   snake_length             live body segments (head excluded)
//   self_hit                 one-cycle pulse: committed head landed on the body
//   x_block, y_block         block of the pixel        (pipeline stage 2)
//   x_local, y_local         offset inside the block   (pipeline stage 2)
//   game_area                pixel lies inside the grid
//   selected_figure          0 empty, 1 head, 2 body, 3 fruit
//   game_enable, game_data   bitmap bit and colour index (0 when unlit)
// -----------------------------------------------------------------------------
module snake_grid_renderer #(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int BLOCK_BITS        = 3,
    parameter int COORD_BITS        = 7,
    parameter int GRID_W            = 80,
    parameter int GRID_H            = 60,
    parameter int MAX_LENGTH        = 16,
    parameter int LEN_BITS          = 5,
    parameter int INIT_X            = 40,
    parameter int INIT_Y            = 30,
    parameter int COMMIT_LINE       = 480
) (
    input  logic                       clock_25,
    input  logic                       reset,
    input  logic [PIXEL_DISPLAY_BIT:0] X,
    input  logic [PIXEL_DISPLAY_BIT:0] Y,
    input  logic [COORD_BITS-1:0]      fruit_x,
    input  logic [COORD_BITS-1:0]      fruit_y,
    input  logic                       move_valid,
    output logic                       move_ready,
    input  logic [COORD_BITS-1:0]      new_head_x,
    input  logic [COORD_BITS-1:0]      new_head_y,
    input  logic                       grow,
    output logic [LEN_BITS-1:0]        snake_length,
    output logic                       self_hit,
    output logic [COORD_BITS-1:0]      x_block,
    output logic [COORD_BITS-1:0]      y_block,
    output logic [BLOCK_BITS-1:0]      x_local,
    output logic [BLOCK_BITS-1:0]      y_local,
    output logic                       game_area,
    output logic [1:0]                 selected_figure,
    output logic                       game_enable,
    output logic [1:0]                 game_data
);

    localparam int PIX_W = PIXEL_DISPLAY_BIT + 1;

    localparam logic [PIX_W-1:0]      AREA_X    = PIX_W'(GRID_W << BLOCK_BITS);
    localparam logic [PIX_W-1:0]      AREA_Y    = PIX_W'(GRID_H << BLOCK_BITS);
    localparam logic [PIX_W-1:0]      COMMIT_Y  = PIX_W'(COMMIT_LINE);
    localparam logic [BLOCK_BITS-1:0] LOCAL_MAX = '1;
    localparam logic [LEN_BITS-1:0]   LEN_MAX   = LEN_BITS'(MAX_LENGTH);

    typedef enum logic [1:0] {
        FIG_EMPTY = 2'd0,
        FIG_HEAD  = 2'd1,
        FIG_BODY  = 2'd2,
        FIG_FRUIT = 2'd3
    } figure_e;

    typedef enum logic {
        MV_IDLE,
        MV_PENDING
    } move_state_e;

    // ------------------------------------------------------------------
    // Pixel pipeline, stage 1: block mapping and area test
    // ------------------------------------------------------------------
    logic [COORD_BITS-1:0] s1_xb_d, s1_yb_d, s1_xb_q, s1_yb_q;
    logic [BLOCK_BITS-1:0] s1_xl_d, s1_yl_d, s1_xl_q, s1_yl_q;
    logic                  s1_area_d, s1_area_q;

    assign s1_xb_d   = COORD_BITS'(X >> BLOCK_BITS);
    assign s1_yb_d   = COORD_BITS'(Y >> BLOCK_BITS);
    assign s1_xl_d   = X[BLOCK_BITS-1:0];
    assign s1_yl_d   = Y[BLOCK_BITS-1:0];
    assign s1_area_d = (X < AREA_X) && (Y < AREA_Y);

    // ------------------------------------------------------------------
    // Snake state
    // ------------------------------------------------------------------
    move_state_e           state_q, state_d;
    logic                  accept, commit;
    logic [COORD_BITS-1:0] head_x_q, head_y_q;
    logic [COORD_BITS-1:0] seg_x_q [MAX_LENGTH];
    logic [COORD_BITS-1:0] seg_y_q [MAX_LENGTH];
    logic [LEN_BITS-1:0]   len_q, len_d;
    logic [COORD_BITS-1:0] pend_x_q, pend_y_q;
    logic                  pend_grow_q;
    logic                  self_hit_q, self_hit_d;

    // The commit test needs a move already pending, so a move accepted on the
    // commit cycle itself waits for the next frame's commit line.
    assign commit = (state_q == MV_PENDING) && (X == '0) && (Y == COMMIT_Y);

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            MV_IDLE: begin
                if (move_valid) begin
                    accept  = 1'b1;
                    state_d = MV_PENDING;
                end
            end
            MV_PENDING: begin
                if (commit) begin
                    state_d = MV_IDLE;
                end
            end
            default: state_d = MV_IDLE;
        endcase
    end

    // Self-collision: the pending head against the pre-commit body. The tail
    // slot counts even when it is about to drop out.
    always_comb begin
        self_hit_d = 1'b0;
        for (int i = 0; i < MAX_LENGTH; i++) begin
            if ((LEN_BITS'(i) < len_q) && (seg_x_q[i] == pend_x_q) && (seg_y_q[i] == pend_y_q)) begin
                self_hit_d = 1'b1;
            end
        end
        self_hit_d = self_hit_d && commit;
    end

    // At MAX_LENGTH a grow is ignored and the shift simply drops the tail.
    always_comb begin
        len_d = len_q;
        if (commit && pend_grow_q && (len_q < LEN_MAX)) begin
            len_d = len_q + LEN_BITS'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            state_q    <= MV_IDLE;
            head_x_q   <= COORD_BITS'(INIT_X);
            head_y_q   <= COORD_BITS'(INIT_Y);
            len_q      <= '0;
            self_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            self_hit_q <= self_hit_d;
            if (commit) begin
                head_x_q <= pend_x_q;
                head_y_q <= pend_y_q;
            end
        end
    end

    // NOTE: segment and pending-move storage has no reset; slots past snake_length are masked and the pending slot is only read while a move is pending.
    always_ff @(posedge clock_25) begin
        if (accept) begin
            pend_x_q    <= new_head_x;
            pend_y_q    <= new_head_y;
            pend_grow_q <= grow;
        end
        if (commit) begin
            seg_x_q[0] <= head_x_q;
            seg_y_q[0] <= head_y_q;
            for (int i = 1; i < MAX_LENGTH; i++) begin
                seg_x_q[i] <= seg_x_q[i-1];
                seg_y_q[i] <= seg_y_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline, stage 2: figure classification and bitmap lookup
    // ------------------------------------------------------------------
    logic    body_match;
    figure_e fig_d;
    logic    lit_d;
    logic [1:0] data_d;

    always_comb begin
        body_match = 1'b0;
        for (int i = 0; i < MAX_LENGTH; i++) begin
            if ((LEN_BITS'(i) < len_q) && (seg_x_q[i] == s1_xb_q) && (seg_y_q[i] == s1_yb_q)) begin
                body_match = 1'b1;
            end
        end
    end

    always_comb begin
        fig_d = FIG_EMPTY;
        if (s1_area_q) begin
            if ((head_x_q == s1_xb_q) && (head_y_q == s1_yb_q)) begin
                fig_d = FIG_HEAD;
            end else if (body_match) begin
                fig_d = FIG_BODY;
            end else if ((fruit_x == s1_xb_q) && (fruit_y == s1_yb_q)) begin
                fig_d = FIG_FRUIT;
            end
        end
    end

    always_comb begin
        lit_d = 1'b0;
        case (fig_d)
            FIG_HEAD:  lit_d = 1'b1;
            // Body blocks leave a one-pixel dark ring so adjacent segments stay distinct.
            FIG_BODY:  lit_d = (s1_xl_q != '0) && (s1_xl_q != LOCAL_MAX) &&
                               (s1_yl_q != '0) && (s1_yl_q != LOCAL_MAX);
            // Fruit is a checkerboard.
            FIG_FRUIT: lit_d = (s1_xl_q[0] == s1_yl_q[0]);
            default:   lit_d = 1'b0;
        endcase
        data_d = lit_d ? fig_d : FIG_EMPTY;
    end

    logic [COORD_BITS-1:0] xb_q, yb_q;
    logic [BLOCK_BITS-1:0] xl_q, yl_q;
    logic                  area_q, lit_q;
    logic [1:0]            fig_q, data_q;

    always_ff @(posedge clock_25) begin
        if (reset) begin
            s1_xb_q   <= '0;
            s1_yb_q   <= '0;
            s1_xl_q   <= '0;
            s1_yl_q   <= '0;
            s1_area_q <= 1'b0;
            xb_q      <= '0;
            yb_q      <= '0;
            xl_q      <= '0;
            yl_q      <= '0;
            area_q    <= 1'b0;
            fig_q     <= '0;
            lit_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            s1_xb_q   <= s1_xb_d;
            s1_yb_q   <= s1_yb_d;
            s1_xl_q   <= s1_xl_d;
            s1_yl_q   <= s1_yl_d;
            s1_area_q <= s1_area_d;
            xb_q      <= s1_xb_q;
            yb_q      <= s1_yb_q;
            xl_q      <= s1_xl_q;
            yl_q      <= s1_yl_q;
            area_q    <= s1_area_q;
            fig_q     <= fig_d;
            lit_q     <= lit_d;
            data_q    <= data_d;
        end
    end

    assign move_ready      = (state_q == MV_IDLE);
    assign snake_length    = len_q;
    assign self_hit        = self_hit_q;
    assign x_block         = xb_q;
    assign y_block         = yb_q;
    assign x_local         = xl_q;
    assign y_local         = yl_q;
    assign game_area       = area_q;
    assign selected_figure = fig_q;
    assign game_enable     = lit_q;
    assign game_data       = data_q;

endmodule

// File: tb/tb_snake_grid_renderer.sv
// -----------------------------------------------------------------------------
// tb_snake_grid_renderer
//
// Directed and randomized stimulus for snake_grid_renderer. Expected values
// come from a behavioural model: the snake is a queue of block coordinates,
// and pixels are classified with plain division/modulo by the block size.
// -----------------------------------------------------------------------------
module tb_snake_grid_renderer;

    localparam int BLK        = 8;
    localparam int GRID_W     = 80;
    localparam int GRID_H     = 60;
    localparam int MAX_LENGTH = 16;
    localparam int INIT_X     = 40;
    localparam int INIT_Y     = 30;

    logic       clock_25;
    logic       reset;
    logic [9:0] X, Y;
    logic [6:0] fruit_x, fruit_y;
    logic       move_valid, move_ready;
    logic [6:0] new_head_x, new_head_y;
    logic       grow;
    logic [4:0] snake_length;
    logic       self_hit;
    logic [6:0] x_block, y_block;
    logic [2:0] x_local, y_local;
    logic       game_area;
    logic [1:0] selected_figure;
    logic       game_enable;
    logic [1:0] game_data;

    snake_grid_renderer dut (
        .clock_25        (clock_25),
        .reset           (reset),
        .X               (X),
        .Y               (Y),
        .fruit_x         (fruit_x),
        .fruit_y         (fruit_y),
        .move_valid      (move_valid),
        .move_ready      (move_ready),
        .new_head_x      (new_head_x),
        .new_head_y      (new_head_y),
        .grow            (grow),
        .snake_length    (snake_length),
        .self_hit        (self_hit),
        .x_block         (x_block),
        .y_block         (y_block),
        .x_local         (x_local),
        .y_local         (y_local),
        .game_area       (game_area),
        .selected_figure (selected_figure),
        .game_enable     (game_enable),
        .game_data       (game_data)
    );

    initial clock_25 = 1'b0;
    always #20 clock_25 = ~clock_25;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state
    int m_hx, m_hy;
    int m_bx[$];
    int m_by[$];
    bit m_pend;
    int m_px, m_py;
    bit m_pg;
    int m_fx, m_fy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_25);
        #1;
    endtask

    function automatic bit in_body(input int bx, input int by);
        for (int i = 0; i < m_bx.size(); i++) begin
            if (m_bx[i] == bx && m_by[i] == by) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_pixel(input int x, input int y,
                                        output int area, output int fig, output int lit);
        int bx = x / BLK;
        int by = y / BLK;
        int lx = x % BLK;
        int ly = y % BLK;
        area = (x < GRID_W * BLK && y < GRID_H * BLK) ? 1 : 0;
        fig  = 0;
        if (area == 1) begin
            if (bx == m_hx && by == m_hy)      fig = 1;
            else if (in_body(bx, by))          fig = 2;
            else if (bx == m_fx && by == m_fy) fig = 3;
        end
        case (fig)
            1:       lit = 1;
            2:       lit = (lx > 0 && lx < BLK - 1 && ly > 0 && ly < BLK - 1) ? 1 : 0;
            3:       lit = ((lx % 2) == (ly % 2)) ? 1 : 0;
            default: lit = 0;
        endcase
    endfunction

    // Hold a pixel long enough for both pipeline stages, then compare every pixel output.
    task automatic check_pixel(input string tag, input int x, input int y);
        int area, fig, lit;
        X       = 10'(x);
        Y       = 10'(y);
        fruit_x = 7'(m_fx);
        fruit_y = 7'(m_fy);
        tick();
        tick();
        model_pixel(x, y, area, fig, lit);
        check({tag, "/x_block"}, 32'(x_block), 32'((x / BLK) % 128));
        check({tag, "/y_block"}, 32'(y_block), 32'((y / BLK) % 128));
        check({tag, "/x_local"}, 32'(x_local), 32'(x % BLK));
        check({tag, "/y_local"}, 32'(y_local), 32'(y % BLK));
        check({tag, "/area"},    32'(game_area), 32'(area));
        check({tag, "/figure"},  32'(selected_figure), 32'(fig));
        check({tag, "/enable"},  32'(game_enable), 32'(lit));
        check({tag, "/data"},    32'(game_data), 32'(lit == 1 ? fig : 0));
    endtask

    task automatic offer(input string tag, input int nx, input int ny, input bit g);
        X          = 10'd5;
        Y          = 10'd5;
        move_valid = 1'b1;
        new_head_x = 7'(nx);
        new_head_y = 7'(ny);
        grow       = g;
        tick();
        move_valid = 1'b0;
        if (!m_pend) begin
            m_pend = 1'b1;
            m_px   = nx;
            m_py   = ny;
            m_pg   = g;
        end
        check({tag, "/ready_low"}, 32'(move_ready), 32'd0);
    endtask

    // Drives one pass over the commit line and applies any pending move to the model.
    task automatic run_commit_line(input string tag);
        bit hit;
        X = 10'd0;
        Y = 10'd479;
        tick();
        check({tag, "/ready_pre"}, 32'(move_ready), m_pend ? 32'd0 : 32'd1);
        X = 10'd0;
        Y = 10'd480;
        tick();
        hit = 1'b0;
        if (m_pend) begin
            hit = in_body(m_px, m_py);
            m_bx.push_front(m_hx);
            m_by.push_front(m_hy);
            if (!(m_pg && (m_bx.size() - 1) < MAX_LENGTH)) begin
                void'(m_bx.pop_back());
                void'(m_by.pop_back());
            end
            m_hx   = m_px;
            m_hy   = m_py;
            m_pend = 1'b0;
        end
        check({tag, "/ready_post"}, 32'(move_ready), 32'd1);
        check({tag, "/length"},     32'(snake_length), 32'(m_bx.size()));
        check({tag, "/self_hit"},   32'(self_hit), 32'(hit));
        X = 10'd1;
        tick();
        check({tag, "/self_hit_drop"}, 32'(self_hit), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        reset      = 1'b1;
        move_valid = 1'b0;
        X          = 10'd0;
        Y          = 10'd0;
        tick();
        tick();
        check({tag, "/ready"},  32'(move_ready), 32'd1);
        check({tag, "/length"}, 32'(snake_length), 32'd0);
        check({tag, "/hit"},    32'(self_hit), 32'd0);
        check({tag, "/area"},   32'(game_area), 32'd0);
        check({tag, "/figure"}, 32'(selected_figure), 32'd0);
        check({tag, "/enable"}, 32'(game_enable), 32'd0);
        check({tag, "/data"},   32'(game_data), 32'd0);
        check({tag, "/x_blk"},  32'(x_block), 32'd0);
        reset = 1'b0;
        m_hx   = INIT_X;
        m_hy   = INIT_Y;
        m_bx.delete();
        m_by.delete();
        m_pend = 1'b0;
    endtask

    initial begin
        int tx, ty;
        reset      = 1'b1;
        X          = '0;
        Y          = '0;
        move_valid = 1'b0;
        new_head_x = '0;
        new_head_y = '0;
        grow       = 1'b0;
        m_fx       = 100;
        m_fy       = 100;
        fruit_x    = 7'(m_fx);
        fruit_y    = 7'(m_fy);

        // Reset and the initial head
        apply_reset("reset");
        check_pixel("head_init", 320, 240);

        // Pipeline latency: two edges from a new pixel to its outputs
        X = 10'd400;
        tick();
        check("latency/old_data", 32'(game_data), 32'd1);
        tick();
        check("latency/new_data", 32'(game_data), 32'd0);
        check("latency/new_xblk", 32'(x_block), 32'd50);

        // First growing move, committed on the commit line
        offer("move1", 41, 30, 1'b1);
        run_commit_line("commit1");
        check_pixel("head_41",    41 * BLK + 3, 30 * BLK + 3);
        check_pixel("body_ring",  40 * BLK + 0, 30 * BLK + 3);
        check_pixel("body_inner", 40 * BLK + 3, 30 * BLK + 3);

        // Fruit checkerboard
        m_fx = 10;
        m_fy = 5;
        check_pixel("fruit_lit",   81, 41);
        check_pixel("fruit_unlit", 81, 42);

        // Fruit on the head: head wins; then a pixel right of the grid
        m_fx = 41;
        m_fy = 30;
        check_pixel("fruit_on_head", 41 * BLK + 2, 30 * BLK + 5);
        check_pixel("outside", 640, 100);
        m_fx = 100;
        m_fy = 100;

        // Move offered on the commit cycle with nothing pending: accepted, committed next frame
        X = 10'd0;
        Y = 10'd479;
        tick();
        X          = 10'd0;
        Y          = 10'd480;
        move_valid = 1'b1;
        new_head_x = 7'd42;
        new_head_y = 7'd30;
        grow       = 1'b0;
        tick();
        move_valid = 1'b0;
        m_pend = 1'b1;
        m_px   = 42;
        m_py   = 30;
        m_pg   = 1'b0;
        check("commit_cycle/ready_low", 32'(move_ready), 32'd0);
        check("commit_cycle/len_same",  32'(snake_length), 32'd1);
        check_pixel("commit_cycle/head_unmoved", 41 * BLK + 4, 30 * BLK + 4);
        run_commit_line("commit_cycle_next");
        check_pixel("commit_cycle/head_moved", 42 * BLK + 4, 30 * BLK + 4);

        // A second offer while pending is ignored
        offer("pend_a", 42, 31, 1'b0);
        offer("pend_b", 10, 10, 1'b1);
        run_commit_line("commit_a");
        check_pixel("ignored/head_a", 42 * BLK + 1, 31 * BLK + 1);
        check_pixel("ignored/not_b",  10 * BLK + 1, 10 * BLK + 1);

        // Reset with a move pending: no commit afterwards
        offer("pend_reset", 45, 45, 1'b1);
        apply_reset("reset_pending");
        run_commit_line("after_reset");
        check_pixel("after_reset/head", 320, 240);
        check_pixel("after_reset/no_move", 45 * BLK + 3, 45 * BLK + 3);

        // Seventeen growing moves: length saturates and the oldest segment leaves
        for (int k = 0; k < 17; k++) begin
            offer("sat_move", 41 + k, 30, 1'b1);
            run_commit_line("sat_commit");
        end
        check("sat/length_16", 32'(snake_length), 32'd16);
        check_pixel("sat/oldest_gone", 40 * BLK + 3, 30 * BLK + 3);
        check_pixel("sat/tail_body",   41 * BLK + 3, 30 * BLK + 3);

        // Head onto seg[3]
        tx = m_bx[3];
        ty = m_by[3];
        offer("hit_move", tx, ty, 1'b0);
        run_commit_line("hit_commit");
        check_pixel("hit/head", tx * BLK + 3, ty * BLK + 3);

        // Randomized moves and pixels against the model
        apply_reset("reset_rand");
        for (int n = 0; n < 40; n++) begin
            offer("rnd_move", 36 + int'($urandom_range(9)), 26 + int'($urandom_range(9)),
                  1'($urandom_range(1)));
            run_commit_line("rnd_commit");
            m_fx = 36 + int'($urandom_range(9));
            m_fy = 26 + int'($urandom_range(9));
            for (int p = 0; p < 3; p++) begin
                if (p == 0) begin
                    check_pixel("rnd_any", int'($urandom_range(699)), int'($urandom_range(479) + 1));
                end else begin
                    check_pixel("rnd_near",
                                (36 + int'($urandom_range(9))) * BLK + int'($urandom_range(7)),
                                (26 + int'($urandom_range(9))) * BLK + int'($urandom_range(7)));
                end
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/snake_grid_renderer.md
# snake_grid_renderer

Parametrised pixel renderer for the Snake VGA path. It maps the scan position (X, Y) onto a grid of square blocks and holds the snake as a head register plus a shift buffer of body segments. It classifies each block as head, body, fruit or empty, and produces the per-pixel colour index for the VGA stage. Snake moves arrive through a valid/ready handshake and are committed only during vertical blanking, so a frame never shows a half-updated snake.

## Interface
- PIXEL_DISPLAY_BIT, 9: MSB index of X/Y
- BLOCK_BITS, 3: log2 of block edge in pixels (block = 8x8)
- COORD_BITS, 7: width of block coordinates
- GRID_W, 80: blocks per row
- GRID_H, 60: blocks per column
- MAX_LENGTH, 16: body segment capacity, excluding head
- LEN_BITS, 5: width of snake_length; must hold MAX_LENGTH
- INIT_X, 40 / INIT_Y, 30: head block after reset
- COMMIT_LINE, 480: Y value on which a pending move commits (X==0)

- clock_25  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-high
- X, Y  in  PIXEL_DISPLAY_BIT+1  current scan position
- fruit_x, fruit_y  in  COORD_BITS  fruit block; sampled every pixel
- move_valid  in  1  new head offered
- move_ready  out  1  no move pending; reset 1
- new_head_x, new_head_y  in  COORD_BITS  next head block
- grow  in  1  with move: keep tail, length+1
- snake_length  out  LEN_BITS  live body segments; reset 0
- self_hit  out  1  one-cycle pulse: committed head overlapped body; reset 0
- x_block, y_block  out  COORD_BITS  block of pixel; reset 0
- x_local, y_local  out  BLOCK_BITS  offset inside block; reset 0
- game_area  out  1  pixel inside grid; reset 0
- selected_figure  out  2  0 empty, 1 head, 2 body, 3 fruit; reset 0
- game_enable  out  1  pixel lit by a figure; reset 0
- game_data  out  2  colour index; 0 when game_enable=0; reset 0

## Operation
- Block mapping:
  - x_block = X >> BLOCK_BITS and x_local = X[BLOCK_BITS-1:0].
  - Y is mapped the same way.
  - Block coordinates are truncated/zero-extended to COORD_BITS.
- game_area = (X < GRID_W<<BLOCK_BITS) && (Y < GRID_H<<BLOCK_BITS). Outside the area, figure, enable and data are all 0.
- Figure priority: head > body > fruit > empty.
  - Body match = any seg[i] equal to the block, for i < snake_length. Comparisons are parallel over all MAX_LENGTH slots.
- Symbol bitmaps, with L = 2^BLOCK_BITS - 1:
  - Head: all pixels lit.
  - Body: lit except the outer ring (local = 0 or L on either axis).
  - Fruit: lit when x_local[0] == y_local[0].
  - Empty: never lit.
- game_enable = bitmap bit. game_data = selected_figure when lit, else 0.
- Move handshake:
  - A move is accepted on a clock edge with move_valid && move_ready.
  - On acceptance, new_head_x/y and grow are latched into a pending register and move_ready drops to 0.
  - A move offered while move_ready=0 is ignored; the producer holds it.
- Commit: happens on the cycle X==0 && Y==COMMIT_LINE while a move is pending.
  - seg[0] ← head; seg[i] ← seg[i-1]; head ← pending head.
  - If grow and snake_length < MAX_LENGTH, snake_length increments. At MAX_LENGTH, grow is ignored and the tail drops.
  - move_ready returns to 1 on the next cycle.
- Commit-cycle acceptance: if move_valid arrives on the commit cycle with nothing pending, it is accepted. It commits on the next frame's commit line, not the current one.
- self_hit:
  - Evaluated at commit: pending head compared against pre-commit seg[i] for i < snake_length. The tail slot is included even when not growing.
  - Registered; high exactly one cycle after the commit edge.
  - The commit still proceeds; the game FSM decides the outcome.
- No range check on new_head coordinates; wrap-around is the producer's job.
- Reset (from any state, including with a move pending):
  - Pending move discarded, move_ready=1, head=(INIT_X, INIT_Y), snake_length=0.
  - Segment contents are don't-care; they are masked by length.
  - Pipeline outputs = 0.

## Timing
- Pixel pipeline: 2 stages; all pixel outputs aligned.
  - Stage 1 registers block/local coordinates and area.
  - Stage 2 registers figure, enable and data, together with the stage-1 coordinates.
  - Given X/Y at edge n, x_block, game_area, selected_figure, game_enable and game_data are valid after edge n+2.
- Snake state sampled by stage 2 reflects commits up to that edge. With default COMMIT_LINE the pipeline is outside the visible area at commit.
- Handshake: accept at edge a → move_ready=0 after a. Commit at edge c → move_ready=1 and snake_length updated after c → self_hit high during cycle c+1 only.

## Test plan
- Reset, then scan X=320,Y=240 (block 40,30), local (0,0) → selected_figure=1, game_data=1 two cycles later; snake_length=0, move_ready=1.
- Move to (41,30) with grow=1, then run to Y=480 X=0 → move_ready low until commit; afterwards snake_length=1, block 41 shows head, block 40 body. Body at local (0,3) → game_enable=0; at (3,3) → game_data=2.
- fruit=(10,5); pixel X=81,Y=41 (local 1,1) → figure 3, lit. Pixel X=81,Y=42 (local 1,2) → unlit, game_data=0.
- Fruit placed on the head block → figure 1 (head wins). Pixel X=640,Y=100 → game_area=0, all data 0.
- 17 grow moves → snake_length saturates at 16. The oldest segment leaves on move 17. Moving head onto seg[3] → self_hit pulses exactly one cycle.
- Move pending, reset asserted → after reset move_ready=1, head=(40,30), snake_length=0, and no commit occurs at the next COMMIT_LINE.
